button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce_pkg.sv | 18 +
 rtl/button_debounce_if.sv | 25 ++
 rtl/button_debounce_sync_2ff.sv | 28 ++
 rtl/button_debounce.sv | 119 +++++++++++
 tb/tb_button_debounce.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_pkg.sv
// Shared constants for the push-button debouncer: FSM state encoding,
// default debounce length and the widths of the switch and press counter.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESS_CHK = 2'b01,
    HELD      = 2'b10,
    REL_CHK   = 2'b11
  } state_t;

  // 10 ms of stable input at a 100 MHz clock
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int CNT_W_DEF           = 20;
  localparam int SW_W                = 7;
  localparam int COUNT_W             = 8;

endpackage

// File: rtl/button_debounce_if.sv
// Signal bundle between the raw button/switch source and the debouncer.
// master drives the raw levels and observes the cleaned results; slave is
// the debouncer itself.
interface button_debounce_if;
  import button_debounce_pkg::*;

  logic               button;
  logic [SW_W-1:0]    sw;
  logic               btn_level;
  logic               btn_pulse;
  logic               btn_release;
  logic [SW_W-1:0]    sw_sample;
  logic [COUNT_W-1:0] press_count;

  modport master (
    output button, sw,
    input  btn_level, btn_pulse, btn_release, sw_sample, press_count
  );

  modport slave (
    input  button, sw,
    output btn_level, btn_pulse, btn_release, sw_sample, press_count
  );

endinterface

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; the output follows
// the input two clock edges later.
module sync_2ff #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;
  logic [DATA_W-1:0] sync_p1;

  // First flop may go metastable; second flop gives it a cycle to settle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes the button and slide switches, qualifies
// press/release by requiring DEBOUNCE_CYCLES stable cycles, emits one-cycle
// press/release strobes, latches the switches on each press and counts presses.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  button_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               sbtn;
  logic [SW_W-1:0]    ssw;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               rel_q, rel_d;
  logic [SW_W-1:0]    sample_q;
  logic [COUNT_W-1:0] presses_q;

  sync_2ff #(.DATA_W(1)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (bus.button),
    .q   (sbtn)
  );

  sync_2ff #(.DATA_W(SW_W)) u_sync_sw (
    .clk (clk),
    .rst (rst),
    .d   (bus.sw),
    .q   (ssw)
  );

  // Next-state, qualification counter and strobe decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sbtn) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sbtn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sbtn) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end
      end
      REL_CHK: begin
        if (sbtn) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered strobes; a confirmed press also latches
  // the synchronized switches seen at that same edge and bumps the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      rel_q     <= 1'b0;
      sample_q  <= '0;
      presses_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
      if (pulse_d) begin
        sample_q  <= ssw;
        presses_q <= presses_q + COUNT_W'(1);
      end
    end
  end

  assign bus.btn_level   = (state_q == HELD) || (state_q == REL_CHK);
  assign bus.btn_pulse   = pulse_q;
  assign bus.btn_release = rel_q;
  assign bus.sw_sample   = sample_q;
  assign bus.press_count = presses_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with DEBOUNCE_CYCLES=4: stimulus pushes expected
// strobes into a queue, a negedge monitor pops and compares them.
module tb_button_debounce;
  import button_debounce_pkg::*;

  localparam int DC  = 4;
  localparam int LAT = DC + 3;

  logic clk = 1'b0;
  logic rst;

  button_debounce_if bus ();

  button_debounce #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses_seen = 0;

  typedef struct {
    bit         pulse;
    int         at;
    logic [6:0] sw;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];

  logic [7:0] model_cnt;
  logic [6:0] model_sample;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input bit p, input int at, input logic [6:0] s, input logic [7:0] c);
    exp_t e;
    e.pulse = p;
    e.at    = at;
    e.sw    = s;
    e.cnt   = c;
    q.push_back(e);
  endtask

  task automatic press(input logic [6:0] s);
    bus.sw       = s;
    bus.button   = 1'b1;
    model_cnt    = model_cnt + 8'd1;
    model_sample = s;
    exp_push(1'b1, cyc + LAT, model_sample, model_cnt);
    step(LAT + 2);
  endtask

  task automatic release_btn();
    bus.button = 1'b0;
    exp_push(1'b0, cyc + LAT, model_sample, model_cnt);
    step(LAT + 2);
  endtask

  // Monitor: every strobe must match the head of the expectation queue
  always @(negedge clk) begin
    exp_t e;
    if (bus.btn_pulse && bus.btn_release)
      check("both_strobes", 32'd1, 32'd0);
    if (bus.btn_pulse || bus.btn_release) begin
      if (bus.btn_pulse) pulses_seen++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: pulse=%0b release=%0b at cycle %0d, required none",
                 bus.btn_pulse, bus.btn_release, cyc);
      end else begin
        e = q.pop_front();
        check(e.pulse ? "pulse_kind" : "release_kind", {31'd0, bus.btn_pulse}, {31'd0, e.pulse});
        check(e.pulse ? "pulse_cycle" : "release_cycle", cyc, e.at);
        check("sw_sample", {25'd0, bus.sw_sample}, {25'd0, e.sw});
        check("press_count", {24'd0, bus.press_count}, {24'd0, e.cnt});
        check("btn_level", {31'd0, bus.btn_level}, {31'd0, e.pulse});
      end
    end else if (q.size() > 0 && q[0].at < cyc) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_strobe: no strobe by required cycle, required %s at cycle %0d",
               e.pulse ? "pulse" : "release", e.at);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int base;
    model_cnt    = 8'd0;
    model_sample = 7'd0;
    rst        = 1'b0;
    bus.button = 1'b0;
    bus.sw     = 7'd0;
    #12;
    check("rst_level",   {31'd0, bus.btn_level},   32'd0);
    check("rst_pulse",   {31'd0, bus.btn_pulse},   32'd0);
    check("rst_release", {31'd0, bus.btn_release}, 32'd0);
    check("rst_sample",  {25'd0, bus.sw_sample},   32'd0);
    check("rst_count",   {24'd0, bus.press_count}, 32'd0);
    step(1);
    rst = 1'b1;
    step(3);

    // Clean press with sw=55, switches change afterwards, long hold
    press(7'h55);
    bus.sw = 7'h2A;
    step(4);
    check("sample_hold", {25'd0, bus.sw_sample}, 32'h55);
    check("level_held",  {31'd0, bus.btn_level}, 32'd1);
    step(20);
    release_btn();
    check("level_idle", {31'd0, bus.btn_level}, 32'd0);
    press(7'h2A);
    release_btn();

    // Bounce on press: 1,1,0 then held
    bus.button = 1'b1;
    step(2);
    bus.button = 1'b0;
    step(1);
    bus.button = 1'b1;
    model_cnt    = model_cnt + 8'd1;
    model_sample = bus.sw;
    exp_push(1'b1, cyc + LAT, model_sample, model_cnt);
    step(LAT + 2);

    // Bounce on release: 0,0,1 then low
    bus.button = 1'b0;
    step(2);
    bus.button = 1'b1;
    step(1);
    release_btn();

    // Switch change landing exactly on the confirming edge is captured
    bus.sw     = 7'h11;
    bus.button = 1'b1;
    c0 = cyc;
    model_cnt    = model_cnt + 8'd1;
    model_sample = 7'h22;
    exp_push(1'b1, c0 + LAT, model_sample, model_cnt);
    step(4);
    bus.sw = 7'h22;
    step(LAT - 2);
    release_btn();

    // One cycle later it is too late for this press
    bus.sw     = 7'h33;
    bus.button = 1'b1;
    c0 = cyc;
    model_cnt    = model_cnt + 8'd1;
    model_sample = 7'h33;
    exp_push(1'b1, c0 + LAT, model_sample, model_cnt);
    step(5);
    bus.sw = 7'h44;
    step(LAT - 3);
    check("late_sw_sample", {25'd0, bus.sw_sample}, 32'h33);
    release_btn();

    // Reset in PRESS_CHK with cnt=2, button kept high through reset
    bus.sw     = 7'h5A;
    bus.button = 1'b1;
    step(5);
    rst = 1'b0;
    #1;
    check("mid_rst_level",  {31'd0, bus.btn_level},   32'd0);
    check("mid_rst_pulse",  {31'd0, bus.btn_pulse},   32'd0);
    check("mid_rst_sample", {25'd0, bus.sw_sample},   32'd0);
    check("mid_rst_count",  {24'd0, bus.press_count}, 32'd0);
    model_cnt    = 8'd1;
    model_sample = 7'h5A;
    step(2);
    rst = 1'b1;
    exp_push(1'b1, cyc + LAT, model_sample, model_cnt);
    step(LAT + 2);

    // Reset while HELD, released with the button up: no strobes at all
    rst = 1'b0;
    #1;
    check("held_rst_level", {31'd0, bus.btn_level},   32'd0);
    check("held_rst_count", {24'd0, bus.press_count}, 32'd0);
    bus.button = 1'b0;
    model_cnt    = 8'd0;
    model_sample = 7'd0;
    step(2);
    rst = 1'b1;
    step(12);

    // 256 presses wrap the counter back to zero
    base = pulses_seen;
    for (int i = 0; i < 256; i++) begin
      press(7'(i));
      release_btn();
    end
    check("wrap_pulses", pulses_seen - base, 32'd256);
    check("wrap_count",  {24'd0, bus.press_count}, 32'd0);

    step(5);
    check("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
